// File: rtl/lsu_mem_initiator.sv
// Load/store unit acting as data-memory initiator: byte-enable generation, store
// data replication, load extraction with sign/zero extension, fault and timeout reporting.
module lsu_mem_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cause_reg, cause_next;

    logic        size_b, size_h, size_w, illegal, misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wd_rep;
    logic [31:0] rd_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        req_int;

    // Sign/zero selection lives in bit 2 of funct3; bits [1:0] give the width.
    assign size_b     = (core_size_i[1:0] == 2'd0);
    assign size_h     = (core_size_i[1:0] == 2'd1);
    assign size_w     = (core_size_i == 3'd2);
    assign illegal    = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11);
    assign misaligned = (size_h && core_addr_i[0]) || (size_w && (core_addr_i[1:0] != 2'b00));

    always_comb begin
        be_dec = 4'b0000;
        if (!illegal) begin
            if (size_b)      be_dec = 4'b0001 << core_addr_i[1:0];
            else if (size_h) be_dec = core_addr_i[1] ? 4'b1100 : 4'b0011;
            else             be_dec = 4'b1111;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wd_lane
            always_comb begin
                if (size_b)      wd_rep[8*gi +: 8] = core_wd_i[7:0];
                else if (size_h) wd_rep[8*gi +: 8] = core_wd_i[8*(gi % 2) +: 8];
                else             wd_rep[8*gi +: 8] = core_wd_i[8*gi +: 8];
            end
        end
    endgenerate

    assign rd_byte = mem_rd_i[8*core_addr_i[1:0] +: 8];
    assign rd_half = mem_rd_i[16*core_addr_i[1] +: 16];

    always_comb begin
        if (size_b)      rd_ext = {{24{rd_byte[7] & ~core_size_i[2]}}, rd_byte};
        else if (size_h) rd_ext = {{16{rd_half[15] & ~core_size_i[2]}}, rd_half};
        else             rd_ext = mem_rd_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cause_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cause_next    = cause_reg;
        req_int       = 1'b0;
        core_rd_o     = 32'd0;
        core_stall_o  = 1'b0;
        core_fault_o  = 1'b0;
        fault_cause_o = 2'b00;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_be_o      = 4'b0000;
        mem_addr_o    = 32'd0;
        mem_wd_o      = 32'd0;
        // Reset masks every output, including the pass-through address and data.
        if (!rst_i) begin
            mem_addr_o = core_addr_i;
            mem_be_o   = be_dec;
            mem_wd_o   = wd_rep;
            unique case (state_reg)
                ST_IDLE: begin
                    if (core_req_i) begin
                        core_stall_o = 1'b1;
                        if (illegal || misaligned) begin
                            state_next = ST_FAULT;
                            cause_next = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        end else begin
                            req_int    = 1'b1;
                            state_next = ST_WAIT;
                            cnt_next   = '0;
                        end
                    end
                end
                ST_WAIT: begin
                    req_int      = 1'b1;
                    core_stall_o = ~mem_ready_i;
                    if (mem_ready_i) begin
                        state_next = ST_IDLE;
                        if (!core_we_i) core_rd_o = rd_ext;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_next = ST_FAULT;
                        cause_next = CAUSE_TIMEOUT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_FAULT: begin
                    core_fault_o  = 1'b1;
                    fault_cause_o = cause_reg;
                    state_next    = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
            mem_req_o = req_int;
            mem_we_o  = req_int & core_we_i;
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus random accesses
// checked against an arithmetic model of lane selection, replication and extension.
module tb_lsu_mem_initiator;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic [1:0]  fault_cause_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int pass_cnt = 0;
    int total    = 0;

    lsu_mem_initiator #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_fault_o(core_fault_o), .fault_cause_o(fault_cause_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] size);
        if (size[1:0] == 2'd0) return 1;
        if (size[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        int lane = int'(addr[1:0]);
        return 4'(((1 << n) - 1) << lane);
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
        int n = nbytes(size);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] mrd);
        int n = nbytes(size);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v = ({32'd0, mrd} >> (8 * int'(addr[1:0]))) & mask;
        if (!size[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One complete access starting in an IDLE cycle; delay = WAIT index where ready rises
    // (delay >= TO means the memory never answers).
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mrd, input int delay,
                          input logic use_exp, input logic [31:0] exp_rd);
        logic ill, mis, done;
        logic [31:0] erd;
        ill = (size == 3'd3) || (size >= 3'd6);
        mis = (!ill) && ((nbytes(size) == 2 && addr[0]) || (nbytes(size) == 4 && addr[1:0] != 2'b00));
        erd = use_exp ? exp_rd : model_rd(size, addr, mrd);
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd; mem_rd_i = mrd; mem_ready_i = 1'b0;
        #2;
        $display("access we=%0d size=%0d addr=0x%08h wd=0x%08h mrd=0x%08h delay=%0d",
                 we, size, addr, wd, mrd, delay);
        chk("idle_stall", 32'(core_stall_o), 32'd1);
        chk("idle_fault", 32'(core_fault_o), 32'd0);
        if (ill || mis) begin
            chk("fault_noreq", 32'(mem_req_o), 32'd0);
            next_cycle(); #2;
            chk("fault_pulse", 32'(core_fault_o), 32'd1);
            chk("fault_cause", 32'(fault_cause_o), ill ? 32'd3 : 32'd1);
            chk("fault_stall", 32'(core_stall_o), 32'd0);
            chk("fault_req", 32'(mem_req_o), 32'd0);
            chk("fault_rd", core_rd_o, 32'd0);
        end else begin
            chk("req", 32'(mem_req_o), 32'd1);
            chk("we", 32'(mem_we_o), 32'(we));
            chk("be", 32'(mem_be_o), 32'(model_be(size, addr)));
            chk("addr", mem_addr_o, addr);
            if (we) chk("wd", mem_wd_o, model_wd(size, wd));
            done = 1'b0;
            for (int j = 0; j < TO; j++) begin
                if (!done) begin
                    next_cycle();
                    mem_ready_i = (j == delay);
                    #2;
                    chk("wait_req", 32'(mem_req_o), 32'd1);
                    chk("wait_stall", 32'(core_stall_o), 32'(j != delay));
                    chk("wait_cause", 32'(fault_cause_o), 32'd0);
                    if (j == delay) begin
                        chk("rd", core_rd_o, we ? 32'd0 : erd);
                        chk("done_fault", 32'(core_fault_o), 32'd0);
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                next_cycle(); mem_ready_i = 1'b0; #2;
                chk("to_fault", 32'(core_fault_o), 32'd1);
                chk("to_cause", 32'(fault_cause_o), 32'd2);
                chk("to_stall", 32'(core_stall_o), 32'd0);
                chk("to_req", 32'(mem_req_o), 32'd0);
            end
        end
        next_cycle();
        core_req_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        #2;
        chk({tag, "_stall"}, 32'(core_stall_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_fault"}, 32'(core_fault_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rdv;
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h100; core_wd_i = 32'hFFFF_FFFF; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
        next_cycle(); next_cycle(); #2;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wd", mem_wd_o, 32'd0);
        next_cycle();
        rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b0;
        check_idle("post_rst");
        next_cycle();

        // SW followed by an idle cycle
        access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 32'h0);
        check_idle("sw_after");
        next_cycle();
        access(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 1'b0, 32'h0);
        access(1'b1, 3'd1, 32'h102, 32'h0000_1234, 32'h0, 1, 1'b0, 32'h0);

        rdv = 32'h80F0_7F81;
        access(1'b0, 3'd0, 32'h200, 32'h0, rdv, 0, 1'b1, 32'hFFFF_FF81);
        access(1'b0, 3'd4, 32'h200, 32'h0, rdv, 0, 1'b1, 32'h0000_0081);
        access(1'b0, 3'd0, 32'h201, 32'h0, rdv, 0, 1'b1, 32'h0000_007F);
        access(1'b0, 3'd1, 32'h202, 32'h0, rdv, 0, 1'b1, 32'hFFFF_80F0);
        access(1'b0, 3'd5, 32'h202, 32'h0, rdv, 0, 1'b1, 32'h0000_80F0);
        access(1'b0, 3'd2, 32'h200, 32'h0, rdv, 0, 1'b1, 32'h80F0_7F81);

        access(1'b0, 3'd2, 32'h102, 32'h0, rdv, 0, 1'b0, 32'h0);
        access(1'b0, 3'd3, 32'h100, 32'h0, rdv, 0, 1'b0, 32'h0);
        access(1'b0, 3'd2, 32'h300, 32'h0, rdv, 99, 1'b0, 32'h0);
        access(1'b0, 3'd2, 32'h300, 32'h0, rdv, 2, 1'b1, 32'h80F0_7F81);

        // Reset while waiting on memory
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h400; core_wd_i = 32'h1111_2222; mem_ready_i = 1'b0;
        #2;
        chk("mid_req", 32'(mem_req_o), 32'd1);
        next_cycle();
        rst_i = 1'b1; #2;
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(core_stall_o), 32'd0);
        chk("mid_rst_be", 32'(mem_be_o), 32'd0);
        chk("mid_rst_we", 32'(mem_we_o), 32'd0);
        next_cycle();
        rst_i = 1'b0; core_req_i = 1'b0;
        check_idle("mid_after");
        chk("mid_after_cause", 32'(fault_cause_o), 32'd0);
        next_cycle();
        access(1'b1, 3'd2, 32'h400, 32'h1111_2222, 32'h0, 0, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
